// File: rtl/z80_io_mailbox.sv
// Z80 I/O mailbox: NUM_CH byte channels in each direction between Z80 I/O ports and a
// host-side port, with full/overflow flags, a status port and an IRQ on pending Z80 writes.

module z80_io_mailbox_ch (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr_commit,
    input  logic [7:0] i_wr_data,
    input  logic       i_rd_done,
    input  logic       i_host_rd,
    input  logic       i_host_wr,
    input  logic [7:0] i_host_wdata,
    output logic [7:0] o_tx,
    output logic       o_tx_full,
    output logic       o_tx_ovf,
    output logic [7:0] o_rx,
    output logic       o_rx_full
);
    logic [7:0] r_tx, r_rx;
    logic       r_tx_full, r_tx_ovf, r_rx_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx      <= '0;
            r_rx      <= '0;
            r_tx_full <= 1'b0;
            r_tx_ovf  <= 1'b0;
            r_rx_full <= 1'b0;
        end else begin
            if (i_wr_commit) r_tx <= i_wr_data;
            if (i_wr_commit)    r_tx_full <= 1'b1;
            else if (i_host_rd) r_tx_full <= 1'b0;
            // A host read clears overflow even if a new commit lands in the same clk
            if (i_host_rd)                     r_tx_ovf <= 1'b0;
            else if (i_wr_commit && r_tx_full) r_tx_ovf <= 1'b1;
            if (i_host_wr) r_rx <= i_host_wdata;
            if (i_host_wr)      r_rx_full <= 1'b1;
            else if (i_rd_done) r_rx_full <= 1'b0;
        end
    end

    assign o_tx      = r_tx;
    assign o_rx      = r_rx;
    assign o_tx_full = r_tx_full;
    assign o_tx_ovf  = r_tx_ovf;
    assign o_rx_full = r_rx_full;
endmodule

module z80_io_mailbox #(
    parameter int          NUM_CH      = 8,
    parameter logic [15:0] BASE_ADDR   = 16'd12345,
    parameter int          ADDR_STRIDE = 2,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       z80_a,
    input  logic [7:0]        z80_d_in,
    output logic [7:0]        z80_d_out,
    output logic              z80_d_drive,
    output logic              z80_d_dir,
    output logic              z80_d_oe,
    input  logic              z80_rd,
    input  logic              z80_wr,
    input  logic              z80_iorq,
    input  logic              z80_mreq,
    input  logic              z80_m1,
    input  logic [2:0]        host_sel,
    input  logic              host_wr,
    input  logic [7:0]        host_wdata,
    input  logic              host_rd,
    output logic [7:0]        host_rdata,
    output logic              host_rvalid,
    output logic [NUM_CH-1:0] tx_full,
    output logic [NUM_CH-1:0] rx_full,
    output logic [NUM_CH-1:0] tx_ovf,
    output logic              irq
);
    localparam logic [15:0] STAT_ADDR = 16'(BASE_ADDR + NUM_CH * ADDR_STRIDE);

    logic [NUM_CH-1:0]      w_hit, w_sel, w_hrd, w_hwr;
    logic [NUM_CH-1:0][7:0] w_tx, w_rx;
    logic                   w_hit_stat, w_io, w_z80_rd;
    logic [7:0]             w_rd_mux, w_host_mux;
    logic                   w_wact, w_ract, w_wcommit, w_rdone;

    logic [SYNC_STAGES-1:0] r_rd_s, r_wr_s, r_iorq_s;
    logic                   r_wact_d, r_ract_d;
    logic [NUM_CH-1:0]      r_wsel, r_rsel;
    logic [7:0]             r_wdata, r_rdata;
    logic                   r_rvalid, r_irq, r_oe;

    assign w_io       = !z80_iorq && z80_mreq && z80_m1;
    assign w_hit_stat = (z80_a == STAT_ADDR);
    assign w_z80_rd   = !z80_rd && z80_wr && w_io && ((|w_hit) || w_hit_stat);

    always_comb begin
        w_rd_mux = 8'h00;
        for (int n = 0; n < NUM_CH; n++)
            if (w_hit[n]) w_rd_mux = w_rx[n];
        if (w_hit_stat) w_rd_mux = 8'(rx_full);
    end

    assign z80_d_drive = w_z80_rd;
    assign z80_d_dir   = !w_z80_rd;
    assign z80_d_out   = w_z80_rd ? w_rd_mux : 8'hFF;
    assign z80_d_oe    = r_oe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_s   <= '1;
            r_wr_s   <= '1;
            r_iorq_s <= '1;
        end else begin
            r_rd_s   <= {r_rd_s[SYNC_STAGES-2:0], z80_rd};
            r_wr_s   <= {r_wr_s[SYNC_STAGES-2:0], z80_wr};
            r_iorq_s <= {r_iorq_s[SYNC_STAGES-2:0], z80_iorq};
        end
    end

    assign w_wact = !r_wr_s[SYNC_STAGES-1] && !r_iorq_s[SYNC_STAGES-1];
    assign w_ract = !r_rd_s[SYNC_STAGES-1] && r_wr_s[SYNC_STAGES-1] && !r_iorq_s[SYNC_STAGES-1];
    // Raw IORQ has already gone high by the last synchronised sample, so the
    // synchronised strobe qualifies the cycle and only MREQ/M1 gate the address here.
    assign w_sel  = w_hit & {NUM_CH{z80_mreq && z80_m1}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wact_d <= 1'b0;
            r_ract_d <= 1'b0;
            r_wsel   <= '0;
            r_rsel   <= '0;
            r_wdata  <= '0;
        end else begin
            r_wact_d <= w_wact;
            r_ract_d <= w_ract;
            if (w_wact) begin
                r_wsel  <= w_sel;
                r_wdata <= z80_d_in;
            end
            if (w_ract) r_rsel <= w_sel;
        end
    end

    assign w_wcommit = r_wact_d && !w_wact;
    assign w_rdone   = r_ract_d && !w_ract;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        assign w_hit[n] = (z80_a == 16'(BASE_ADDR + n * ADDR_STRIDE));
        assign w_hrd[n] = host_rd && (host_sel == 3'(n));
        assign w_hwr[n] = host_wr && (host_sel == 3'(n));

        z80_io_mailbox_ch u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_wr_commit  (w_wcommit && r_wsel[n]),
            .i_wr_data    (r_wdata),
            .i_rd_done    (w_rdone && r_rsel[n]),
            .i_host_rd    (w_hrd[n]),
            .i_host_wr    (w_hwr[n]),
            .i_host_wdata (host_wdata),
            .o_tx         (w_tx[n]),
            .o_tx_full    (tx_full[n]),
            .o_tx_ovf     (tx_ovf[n]),
            .o_rx         (w_rx[n]),
            .o_rx_full    (rx_full[n])
        );
    end

    always_comb begin
        w_host_mux = 8'h00;
        for (int n = 0; n < NUM_CH; n++)
            if (host_sel == 3'(n)) w_host_mux = w_tx[n];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_irq    <= 1'b0;
            r_oe     <= 1'b1;
        end else begin
            r_rvalid <= host_rd;
            if (host_rd) r_rdata <= w_host_mux;
            r_irq    <= |tx_full;
            r_oe     <= 1'b0;
        end
    end

    assign host_rdata  = r_rdata;
    assign host_rvalid = r_rvalid;
    assign irq         = r_irq;
endmodule

// File: tb/tb_z80_io_mailbox.sv
// Bench for z80_io_mailbox: event-level mailbox model compared every cycle, directed
// scenarios with literal expectations, then randomized host/Z80 traffic.

module tb_z80_io_mailbox;
    localparam int NCH  = 8;
    localparam int BASE = 12345;
    localparam int STR  = 2;
    localparam int SYN  = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [15:0]    z80_a = '0;
    logic [7:0]     z80_d_in = '0;
    logic [7:0]     z80_d_out;
    logic           z80_d_drive, z80_d_dir, z80_d_oe;
    logic           z80_rd = 1'b1, z80_wr = 1'b1, z80_iorq = 1'b1, z80_mreq = 1'b1, z80_m1 = 1'b1;
    logic [2:0]     host_sel = '0;
    logic           host_wr = 1'b0, host_rd = 1'b0;
    logic [7:0]     host_wdata = '0;
    logic [7:0]     host_rdata;
    logic           host_rvalid;
    logic [NCH-1:0] tx_full, rx_full, tx_ovf;
    logic           irq;

    always #5 clk = ~clk;

    z80_io_mailbox #(.NUM_CH(NCH), .BASE_ADDR(16'(BASE)), .ADDR_STRIDE(STR), .SYNC_STAGES(SYN)) dut (
        .clk(clk), .rst(rst), .z80_a(z80_a), .z80_d_in(z80_d_in), .z80_d_out(z80_d_out),
        .z80_d_drive(z80_d_drive), .z80_d_dir(z80_d_dir), .z80_d_oe(z80_d_oe),
        .z80_rd(z80_rd), .z80_wr(z80_wr), .z80_iorq(z80_iorq), .z80_mreq(z80_mreq), .z80_m1(z80_m1),
        .host_sel(host_sel), .host_wr(host_wr), .host_wdata(host_wdata), .host_rd(host_rd),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .tx_full(tx_full), .rx_full(rx_full), .tx_ovf(tx_ovf), .irq(irq)
    );

    // Mailbox model state
    logic [7:0]     m_tx [NCH];
    logic [7:0]     m_rx [NCH];
    logic [NCH-1:0] m_txf = '0, m_rxf = '0, m_ovf = '0;
    logic           m_irq = 1'b0, m_rvalid = 1'b0, m_oe = 1'b1;
    logic [7:0]     m_rdata = '0;
    int             cyc = 0;
    // Pending Z80 cycle effect, landing SYN+1 clks after the strobes are released
    int             pend_due = -1;
    int             pend_ch = -1;
    bit             pend_wr = 1'b0;
    logic [7:0]     pend_d = '0;
    bit             rnd_host = 1'b0;
    int             n_chk = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [NCH-1:0] old_txf;
        bit cw, cr, hs_ok;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin m_tx[i] = '0; m_rx[i] = '0; end
            m_txf = '0; m_rxf = '0; m_ovf = '0;
            m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_oe = 1'b1;
            return;
        end
        cyc++;
        old_txf  = m_txf;
        hs_ok    = int'(host_sel) < NCH;
        m_oe     = 1'b0;
        m_irq    = |old_txf;
        m_rvalid = host_rd;
        if (host_rd) m_rdata = hs_ok ? m_tx[host_sel] : 8'h00;
        cw = (pend_due == cyc) && pend_wr && (pend_ch >= 0);
        cr = (pend_due == cyc) && !pend_wr && (pend_ch >= 0);
        if (host_rd && hs_ok) m_txf[host_sel] = 1'b0;
        if (cw) begin
            m_tx[pend_ch]  = pend_d;
            m_txf[pend_ch] = 1'b1;
            if (old_txf[pend_ch]) m_ovf[pend_ch] = 1'b1;
        end
        if (host_rd && hs_ok) m_ovf[host_sel] = 1'b0;
        if (cr) m_rxf[pend_ch] = 1'b0;
        if (host_wr && hs_ok) begin
            m_rx[host_sel]  = host_wdata;
            m_rxf[host_sel] = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    task automatic exp_bus(output logic drv, output logic [7:0] dout);
        int off;
        drv  = 1'b0;
        dout = 8'hFF;
        off  = int'(z80_a) - BASE;
        if (!z80_rd && z80_wr && !z80_iorq && z80_mreq && z80_m1 &&
            off >= 0 && (off % STR) == 0 && (off / STR) <= NCH) begin
            drv  = 1'b1;
            dout = ((off / STR) == NCH) ? 8'(m_rxf) : m_rx[off / STR];
        end
    endtask

    initial begin
        logic       edrv;
        logic [7:0] eout;
        forever begin
            @(negedge clk);
            chk("tx_full", 32'(tx_full), 32'(m_txf));
            chk("rx_full", 32'(rx_full), 32'(m_rxf));
            chk("tx_ovf", 32'(tx_ovf), 32'(m_ovf));
            chk("irq", 32'(irq), 32'(m_irq));
            chk("host_rvalid", 32'(host_rvalid), 32'(m_rvalid));
            if (m_rvalid) chk("host_rdata", 32'(host_rdata), 32'(m_rdata));
            chk("z80_d_oe", 32'(z80_d_oe), 32'(m_oe));
            exp_bus(edrv, eout);
            chk("z80_d_drive", 32'(z80_d_drive), 32'(edrv));
            chk("z80_d_dir", 32'(z80_d_dir), 32'(!edrv));
            chk("z80_d_out", 32'(z80_d_out), 32'(eout));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rtick();
        if (rnd_host) begin
            host_rd    = ($urandom % 4) == 0;
            host_wr    = ($urandom % 4) == 0;
            host_sel   = 3'($urandom);
            host_wdata = 8'($urandom);
        end
        tick();
        host_rd = 1'b0;
        host_wr = 1'b0;
    endtask

    task automatic host_write(input int sel, input logic [7:0] d);
        host_sel = 3'(sel); host_wdata = d; host_wr = 1'b1;
        tick();
        host_wr = 1'b0;
    endtask

    task automatic host_read(input int sel);
        host_sel = 3'(sel); host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
    endtask

    task automatic z80_begin(input bit wr, input int a, input logic [7:0] d, input bit mreq, input bit m1);
        z80_a = 16'(a); z80_d_in = d; z80_mreq = mreq; z80_m1 = m1;
        tick();
        z80_iorq = 1'b0;
        if (wr) z80_wr = 1'b0;
        else    z80_rd = 1'b0;
        repeat (3) rtick();
    endtask

    task automatic z80_release();
        int off;
        off     = int'(z80_a) - BASE;
        pend_wr = !z80_wr;
        pend_d  = z80_d_in;
        pend_ch = (z80_mreq && z80_m1 && off >= 0 && (off % STR) == 0 && (off / STR) < NCH) ? off / STR : -1;
        z80_iorq = 1'b1; z80_rd = 1'b1; z80_wr = 1'b1;
        pend_due = cyc + SYN + 1;
    endtask

    task automatic z80_finish();
        repeat (SYN + 3) rtick();
    endtask

    task automatic z80_cyc(input bit wr, input int a, input logic [7:0] d, input bit mreq, input bit m1);
        z80_begin(wr, a, d, mreq, m1);
        z80_release();
        z80_finish();
    endtask

    task automatic wait_due_minus1();
        int g = 0;
        while (cyc < pend_due - 1 && g < 50) begin tick(); g++; end
        chk("due_reached", 32'(cyc), 32'(pend_due - 1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r, ch, a;
        // Reset state and d_oe release
        repeat (3) tick();
        chk("rst_tx_full", 32'(tx_full), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_oe", 32'(z80_d_oe), 32'h1);
        chk("rst_rvalid", 32'(host_rvalid), 32'h0);
        chk("rst_rdata", 32'(host_rdata), 32'h0);
        rst = 1'b0;
        #1 chk("oe_at_release", 32'(z80_d_oe), 32'h1);
        tick();
        chk("oe_one_clk_after", 32'(z80_d_oe), 32'h0);

        // OUT 0xA5 to channel 2, then host read
        z80_cyc(1, BASE + 2 * STR, 8'hA5, 1, 1);
        chk("out_tx_full2", 32'(tx_full[2]), 32'h1);
        chk("out_irq", 32'(irq), 32'h1);
        host_read(2);
        chk("hrd_rvalid", 32'(host_rvalid), 32'h1);
        chk("hrd_rdata_a5", 32'(host_rdata), 32'hA5);
        chk("hrd_tx_full2", 32'(tx_full[2]), 32'h0);

        // Overflow on channel 0, newest data wins
        z80_cyc(1, BASE, 8'h11, 1, 1);
        z80_cyc(1, BASE, 8'h22, 1, 1);
        chk("ovf_set0", 32'(tx_ovf[0]), 32'h1);
        host_read(0);
        chk("ovf_rdata_22", 32'(host_rdata), 32'h22);
        chk("ovf_clr0", 32'(tx_ovf[0]), 32'h0);

        // Host to Z80 on channel 7, status port before and after
        host_write(7, 8'h5A);
        z80_begin(0, BASE + NCH * STR, 8'h00, 1, 1);
        chk("stat_80", 32'(z80_d_out), 32'h80);
        chk("stat_drive", 32'(z80_d_drive), 32'h1);
        z80_release(); z80_finish();
        z80_begin(0, BASE + 7 * STR, 8'h00, 1, 1);
        chk("in7_data", 32'(z80_d_out), 32'h5A);
        chk("in7_dir", 32'(z80_d_dir), 32'h0);
        z80_release(); z80_finish();
        chk("in7_rx_full", 32'(rx_full[7]), 32'h0);
        z80_begin(0, BASE + NCH * STR, 8'h00, 1, 1);
        chk("stat_00", 32'(z80_d_out), 32'h00);
        z80_release(); z80_finish();

        // host_wr and Z80 read completion on channel 3 in the same clk
        host_write(3, 8'h77);
        z80_begin(0, BASE + 3 * STR, 8'h00, 1, 1);
        z80_release();
        wait_due_minus1();
        host_sel = 3'd3; host_wdata = 8'h3C; host_wr = 1'b1;
        tick();
        host_wr = 1'b0;
        chk("coll_rx_full3", 32'(rx_full[3]), 32'h1);
        z80_finish();
        z80_begin(0, BASE + 3 * STR, 8'h00, 1, 1);
        chk("coll_rx_data3", 32'(z80_d_out), 32'h3C);
        z80_release(); z80_finish();

        // host_rd and Z80 write commit on channel 1 in the same clk
        z80_cyc(1, BASE + 1 * STR, 8'h44, 1, 1);
        z80_begin(1, BASE + 1 * STR, 8'h55, 1, 1);
        z80_release();
        wait_due_minus1();
        host_sel = 3'd1; host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
        chk("coll_old_tx", 32'(host_rdata), 32'h44);
        chk("coll_tx_full1", 32'(tx_full[1]), 32'h1);
        chk("coll_ovf1", 32'(tx_ovf[1]), 32'h0);
        z80_finish();
        host_read(1);
        chk("coll_new_tx", 32'(host_rdata), 32'h55);

        // Non-matching address and MREQ-active cycles
        z80_begin(0, BASE + 1, 8'h00, 1, 1);
        chk("odd_addr_drive", 32'(z80_d_drive), 32'h0);
        z80_release(); z80_finish();
        z80_cyc(1, BASE + 1, 8'h99, 1, 1);
        z80_begin(0, BASE, 8'h00, 0, 1);
        chk("mreq_drive", 32'(z80_d_drive), 32'h0);
        z80_release(); z80_finish();
        z80_cyc(1, BASE, 8'h66, 0, 1);
        chk("mreq_no_commit", 32'(tx_full[0]), 32'h0);

        // Mid-run reset with flags set
        z80_cyc(1, BASE + 4 * STR, 8'h12, 1, 1);
        host_write(5, 8'h34);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_full", 32'(tx_full), 32'h0);
        chk("mid_rst_rx_full", 32'(rx_full), 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        chk("mid_rst_oe", 32'(z80_d_oe), 32'h1);
        tick(); tick();
        rst = 1'b0;
        #1 chk("mid_oe_release", 32'(z80_d_oe), 32'h1);
        tick();
        chk("mid_oe_after", 32'(z80_d_oe), 32'h0);

        // Randomized traffic
        rnd_host = 1'b1;
        repeat (250) begin
            r  = int'($urandom % 4);
            ch = int'($urandom % NCH);
            case (int'($urandom % 10))
                0:       a = BASE + 1 + 2 * ch;
                1:       a = BASE + NCH * STR;
                2:       a = BASE - 2;
                default: a = BASE + ch * STR;
            endcase
            case (r)
                0: host_write(ch, 8'($urandom));
                1: host_read(ch);
                2: z80_cyc(1, a, 8'($urandom), ($urandom % 8) != 0, ($urandom % 8) != 0);
                default: z80_cyc(0, a, 8'h00, ($urandom % 8) != 0, ($urandom % 8) != 0);
            endcase
        end
        rnd_host = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
